// File: rtl/pool_fc_flatten_bridge.sv
// pool_fc_flatten_bridge
//   Serialises pooled pixel vectors (input_channels words per beat) into the
//   fc_layer input-buffer write port, one word per cycle. Vectors are queued in
//   a small FIFO. Once a full frame (input_size words) has been written, the fc
//   start pulse is issued and the bridge holds until the fc layer has finished.
//
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-low reset
//     i_valid/i_data  pool pixel vector beat (i_data[c] is channel c)
//     o_next_busy     back-pressure to the pool stage
//     o_ibuf_we/o_ibuf_wr_data/o_ibuf_addr   fc input-buffer write port
//     o_fc_start      one-cycle fc start pulse;  i_fc_busy  fc busy flag
//     o_ovf           sticky: a vector arrived while the FIFO was full
//
//   Build option FLATTEN_HWC_EN: pixel-interleaved addressing
//   (addr = p*input_channels + c) instead of channel-major
//   (addr = c*pix_count + p).
module pool_fc_flatten_bridge #(
  parameter int unsigned input_channels = 10,
  parameter int unsigned out_width      = 11,
  parameter int unsigned datatype_size  = 4,
  parameter int unsigned fifo_depth     = 4,
  localparam int unsigned input_size    = input_channels * out_width * out_width,
  localparam int unsigned addr_w        = $clog2(input_size)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_valid,
  input  logic [input_channels-1:0][datatype_size-1:0]  i_data,
  output logic                                          o_next_busy,
  output logic                                          o_ibuf_we,
  output logic [datatype_size-1:0]                      o_ibuf_wr_data,
  output logic [addr_w-1:0]                             o_ibuf_addr,
  output logic                                          o_fc_start,
  input  logic                                          i_fc_busy,
  output logic                                          o_ovf
);

  localparam int unsigned pix_count = out_width * out_width;
  localparam int unsigned ptr_w     = $clog2(fifo_depth);
  localparam int unsigned cnt_w     = ptr_w + 1;
  localparam int unsigned ch_w      = (input_channels > 1) ? $clog2(input_channels) : 1;
  localparam int unsigned pix_w     = (pix_count > 1) ? $clog2(pix_count) : 1;

  typedef logic [input_channels-1:0][datatype_size-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, WRITE, START_WAIT, HOLD} state_t;

  vec_t             mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  state_t           state;
  logic [ch_w-1:0]  c;
  logic [pix_w-1:0] p;
  logic [addr_w-1:0] addr;
  logic [1:0]       hold_cnt;
  logic             seen_busy;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic             last_ch_c;
  logic             last_pix_c;
  logic             enter_hold_c;
  logic             leave_hold_c;
  logic             hold_nxt_c;
  logic [cnt_w-1:0] count_nxt_c;

  // FIFO status, handshake conditions and the next-cycle HOLD flag for back-pressure
  always_comb begin
    full_c       = (count == cnt_w'(fifo_depth));
    empty_c      = (count == '0);
    push_c       = i_valid & ~full_c;
    last_ch_c    = (c == ch_w'(input_channels - 1));
    last_pix_c   = (p == pix_w'(pix_count - 1));
    pop_c        = (state == WRITE) & last_ch_c;
    count_nxt_c  = count + cnt_w'(push_c) - cnt_w'(pop_c);
    enter_hold_c = (state == START_WAIT) & ~i_fc_busy;
    // fc done: busy seen then dropped, or busy never rose within two cycles of the pulse
    leave_hold_c = (state == HOLD) & ~i_fc_busy & (seen_busy | (hold_cnt == 2'd2));
    hold_nxt_c   = enter_hold_c | ((state == HOLD) & ~leave_hold_c);
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(fifo_depth); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Control FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= IDLE;
      c              <= '0;
      p              <= '0;
      addr           <= '0;
      hold_cnt       <= '0;
      seen_busy      <= 1'b0;
      o_next_busy    <= 1'b0;
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_fc_start     <= 1'b0;
      o_ovf          <= 1'b0;
    end else begin
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_fc_start     <= 1'b0;

      count <= count_nxt_c;
      if (push_c) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ptr_w'(1);
      if (i_valid & full_c) o_ovf <= 1'b1;
      // flag one entry early so a push landing with the flag still low cannot overflow
      o_next_busy <= (count_nxt_c >= cnt_w'(fifo_depth - 1)) | hold_nxt_c;

      case (state)
        IDLE: begin
          if (!empty_c) state <= WRITE;
        end
        WRITE: begin
          o_ibuf_we      <= 1'b1;
          o_ibuf_wr_data <= mem[rd_ptr][c];
          o_ibuf_addr    <= addr;
          if (last_ch_c) begin
            c <= '0;
            if (last_pix_c) begin
              addr  <= '0;
              state <= START_WAIT;
            end else begin
              p <= p + pix_w'(1);
`ifdef FLATTEN_HWC_EN
              addr <= addr + addr_w'(1);
`else
              // next pixel's channel-0 address is simply the next pixel index
              addr <= addr_w'(p) + addr_w'(1);
`endif
              if (count_nxt_c == '0) state <= IDLE;
            end
          end else begin
            c <= c + ch_w'(1);
`ifdef FLATTEN_HWC_EN
            addr <= addr + addr_w'(1);
`else
            addr <= addr + addr_w'(pix_count);
`endif
          end
        end
        START_WAIT: begin
          if (enter_hold_c) begin
            o_fc_start <= 1'b1;
            p          <= '0;
            hold_cnt   <= '0;
            seen_busy  <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (leave_hold_c) begin
            state <= IDLE;
          end else begin
            if (i_fc_busy) seen_busy <= 1'b1;
            if (hold_cnt != 2'd2) hold_cnt <= hold_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
